// File: rtl/riscv_carga_pkg.sv
// ---------------------------------------------------------------------------
// riscv_carga_pkg: load types, load-unit states and alignment rule | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_carga_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [2:0] {
      LB     = 3'b000,
      LH     = 3'b001,
      LW     = 3'b010,
      LD     = 3'b011,
      LBU    = 3'b100,
      LHU    = 3'b101,
      LWU    = 3'b110,
      ILEGAL = 3'b111
   } tipo_carga_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LEITURA = 2'd1,
      ESPERA  = 2'd2,
      FIM     = 2'd3
   } estado_carga_t;

   function automatic logic desalinhado_f(input tipo_carga_t tipo, input logic [2:0] off);
      case (tipo)
         LB, LBU: return 1'b0;
         LH, LHU: return off[0];
         LW, LWU: return |off[1:0];
         LD:      return |off;
         default: return 1'b1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/extensor_carga.sv
// ---------------------------------------------------------------------------
// extensor_carga: selects the addressed field of a 64-bit read and extends it | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module extensor_carga
   import riscv_carga_pkg::*;
(
   input  tipo_carga_t       tipo_i,
   input  logic [2:0]        off_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] dado_o,
   output logic              desalinhado_o
);

   logic [DATA_W-1:0] desloc;

   // Aligned fields never cross the top of the word, so one right shift suffices.
   assign desloc = rdata_i >> {off_i, 3'b000};

   always_comb begin
      dado_o = '0;
      case (tipo_i)
         LB:      dado_o = {{56{desloc[7]}},  desloc[7:0]};
         LH:      dado_o = {{48{desloc[15]}}, desloc[15:0]};
         LW:      dado_o = {{32{desloc[31]}}, desloc[31:0]};
         LD:      dado_o = desloc;
         LBU:     dado_o = {56'd0, desloc[7:0]};
         LHU:     dado_o = {48'd0, desloc[15:0]};
         LWU:     dado_o = {32'd0, desloc[31:0]};
         default: dado_o = '0;
      endcase
   end

   assign desalinhado_o = desalinhado_f(tipo_i, off_i);

endmodule

`default_nettype wire

// File: rtl/unidade_carga_memoria.sv
// ---------------------------------------------------------------------------
// unidade_carga_memoria: multicycle RISC-V load unit (one aligned 64-bit read) | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module unidade_carga_memoria
   import riscv_carga_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [2:0]        funct3_i,
   input  logic [DATA_W-1:0] endereco_i,
   output logic              mem_rd_o,
   output logic [DATA_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] dado_o,
   output logic              done_o,
   output logic              busy_o,
   output logic              erro_alinh_o
);

   estado_carga_t     estado_q, estado_d;
   tipo_carga_t       tipo_q, tipo_d;
   logic [2:0]        off_q, off_d;
   logic [3:0]        cont_q, cont_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dado_q, dado_d;

   logic [DATA_W-1:0] dado_ext;
   logic              desalinhado;

   extensor_carga u_extensor (
      .tipo_i        (tipo_q),
      .off_i         (off_q),
      .rdata_i       (mem_rdata_i),
      .dado_o        (dado_ext),
      .desalinhado_o (desalinhado)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         estado_q <= IDLE;
         tipo_q   <= LB;
         off_q    <= '0;
         cont_q   <= '0;
         addr_q   <= '0;
         dado_q   <= '0;
      end else begin
         estado_q <= estado_d;
         tipo_q   <= tipo_d;
         off_q    <= off_d;
         cont_q   <= cont_d;
         addr_q   <= addr_d;
         dado_q   <= dado_d;
      end
   end

   // A rejected load still spends one cycle in LEITURA (without the read strobe)
   // so that its done pulse lands one cycle after accept.
   always_comb begin
      estado_d = estado_q;
      tipo_d   = tipo_q;
      off_d    = off_q;
      cont_d   = cont_q;
      addr_d   = addr_q;
      dado_d   = dado_q;
      case (estado_q)
         IDLE: begin
            if (start_i) begin
               tipo_d   = tipo_carga_t'(funct3_i);
               off_d    = endereco_i[2:0];
               estado_d = LEITURA;
               if (!desalinhado_f(tipo_carga_t'(funct3_i), endereco_i[2:0]))
                  addr_d = {endereco_i[DATA_W-1:3], 3'b000};
            end
         end
         LEITURA: begin
            if (desalinhado) begin
               dado_d   = '0;
               estado_d = FIM;
            end else begin
               cont_d   = 4'(MEM_LAT - 1);
               estado_d = ESPERA;
            end
         end
         ESPERA: begin
            if (cont_q == 4'd0) begin
               dado_d   = dado_ext;
               estado_d = FIM;
            end else begin
               cont_d = cont_q - 4'd1;
            end
         end
         FIM:     estado_d = IDLE;
         default: estado_d = IDLE;
      endcase
   end

   assign mem_rd_o     = (estado_q == LEITURA) && !desalinhado;
   assign mem_addr_o   = addr_q;
   assign dado_o       = dado_q;
   assign done_o       = (estado_q == FIM);
   assign erro_alinh_o = (estado_q == FIM) && desalinhado;
   assign busy_o       = (estado_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_unidade_carga_memoria.sv
// ---------------------------------------------------------------------------
// tb_unidade_carga_memoria: three latencies (1,3,4) driven together, checked against a timeline model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_unidade_carga_memoria;

   localparam int LAT [3] = '{1, 3, 4};
   localparam logic [63:0] LIXO = 64'hA5A5_5A5A_C3C3_3C3C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [63:0] endereco = '0;
   logic [63:0] rdata_v = '0;

   logic        mem_rd   [3];
   logic [63:0] mem_addr [3];
   logic [63:0] mem_rdata[3];
   logic [63:0] dado     [3];
   logic        done     [3];
   logic        busy     [3];
   logic        erro     [3];

   always #5 clk = ~clk;

   unidade_carga_memoria #(.MEM_LAT(1)) u_dut1 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .funct3_i(funct3), .endereco_i(endereco),
      .mem_rd_o(mem_rd[0]), .mem_addr_o(mem_addr[0]), .mem_rdata_i(mem_rdata[0]),
      .dado_o(dado[0]), .done_o(done[0]), .busy_o(busy[0]), .erro_alinh_o(erro[0]));

   unidade_carga_memoria #(.MEM_LAT(3)) u_dut3 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .funct3_i(funct3), .endereco_i(endereco),
      .mem_rd_o(mem_rd[1]), .mem_addr_o(mem_addr[1]), .mem_rdata_i(mem_rdata[1]),
      .dado_o(dado[1]), .done_o(done[1]), .busy_o(busy[1]), .erro_alinh_o(erro[1]));

   unidade_carga_memoria #(.MEM_LAT(4)) u_dut4 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .funct3_i(funct3), .endereco_i(endereco),
      .mem_rd_o(mem_rd[2]), .mem_addr_o(mem_addr[2]), .mem_rdata_i(mem_rdata[2]),
      .dado_o(dado[2]), .done_o(done[2]), .busy_o(busy[2]), .erro_alinh_o(erro[2]));

   // Memory: data is only valid in the single cycle LAT after the strobe.
   int age [3] = '{0, 0, 0};
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (mem_rd[k])                         age[k] <= 1;
         else if (age[k] != 0 && age[k] < 100)  age[k] <= age[k] + 1;
      end
   end
   always_comb begin
      for (int k = 0; k < 3; k++)
         mem_rdata[k] = (age[k] == LAT[k]) ? rdata_v : LIXO;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic load_illegal(input logic [2:0] f3, input logic [2:0] off);
      int nbytes;
      nbytes = 1 << f3[1:0];
      return (f3 == 3'b111) || ((int'(off) % nbytes) != 0);
   endfunction

   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] w);
      int nbytes;
      logic [63:0] mask, field;
      nbytes = 1 << f3[1:0];
      if (load_illegal(f3, off)) return 64'd0;
      mask  = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
      field = (w >> (8 * int'(off))) & mask;
      if (!f3[2] && nbytes < 8 && field[8 * nbytes - 1]) field = field | ~mask;
      return field;
   endfunction

   // Timeline model: each accepted load fixes its strobe, done and busy cycles.
   int          cyc = 0;
   bit          active  [3] = '{0, 0, 0};
   bit          illegal [3] = '{0, 0, 0};
   int          acc_cyc [3] = '{0, 0, 0};
   int          done_cyc[3] = '{0, 0, 0};
   int          free_at [3] = '{0, 0, 0};
   logic [63:0] pend    [3] = '{0, 0, 0};
   logic [63:0] dado_exp[3] = '{0, 0, 0};
   logic [63:0] addr_exp[3] = '{0, 0, 0};

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            active[k]   = 1'b0;
            free_at[k]  = 0;
            dado_exp[k] = '0;
            addr_exp[k] = '0;
         end else begin
            if (active[k] && cyc == done_cyc[k]) dado_exp[k] = pend[k];
            if (cyc >= free_at[k] && start) begin
               illegal[k]  = load_illegal(funct3, endereco[2:0]);
               pend[k]     = ref_load(funct3, endereco[2:0], rdata_v);
               acc_cyc[k]  = cyc;
               done_cyc[k] = cyc + 1 + (illegal[k] ? 0 : LAT[k]);
               free_at[k]  = done_cyc[k] + 2;
               active[k]   = 1'b1;
               if (!illegal[k]) addr_exp[k] = {endereco[63:3], 3'b000};
            end
         end
      end
   end

   int rd_cnt[3]   = '{0, 0, 0};
   int done_cnt[3] = '{0, 0, 0};
   int busy_cnt[3] = '{0, 0, 0};
   int obs_lat[3]  = '{0, 0, 0};
   logic obs_err[3] = '{0, 0, 0};

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic e_done, e_err, e_busy, e_rd;
         if (reset) begin
            e_done = 0; e_err = 0; e_busy = 0; e_rd = 0;
         end else begin
            e_done = active[k] && cyc == done_cyc[k];
            e_err  = e_done && illegal[k];
            e_busy = active[k] && cyc >= acc_cyc[k] && cyc <= done_cyc[k];
            e_rd   = active[k] && !illegal[k] && cyc == acc_cyc[k];
         end
         chk($sformatf("done[%0d]@%0d", k, cyc),     64'(done[k]),   64'(e_done));
         chk($sformatf("erro[%0d]@%0d", k, cyc),     64'(erro[k]),   64'(e_err));
         chk($sformatf("busy[%0d]@%0d", k, cyc),     64'(busy[k]),   64'(e_busy));
         chk($sformatf("mem_rd[%0d]@%0d", k, cyc),   64'(mem_rd[k]), 64'(e_rd));
         chk($sformatf("dado[%0d]@%0d", k, cyc),     dado[k],        reset ? 64'd0 : dado_exp[k]);
         chk($sformatf("mem_addr[%0d]@%0d", k, cyc), mem_addr[k],    reset ? 64'd0 : addr_exp[k]);
         if (!reset) begin
            if (mem_rd[k]) rd_cnt[k]++;
            if (busy[k])   busy_cnt[k]++;
            if (done[k]) begin
               done_cnt[k]++;
               obs_lat[k] = cyc - acc_cyc[k];
               obs_err[k] = erro[k];
            end
         end
      end
   end

   int rd0[3], done0[3], busy0[3];

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic snap();
      for (int k = 0; k < 3; k++) begin
         rd0[k] = rd_cnt[k]; done0[k] = done_cnt[k]; busy0[k] = busy_cnt[k];
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      step();
      while ((busy[0] || busy[1] || busy[2]) && n < 40) begin
         step();
         n++;
      end
      chk("wait_idle_timeout", 64'(n >= 40), 64'd0);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
      snap();
      step();
      funct3 = f3; endereco = a; rdata_v = d; start = 1'b1;
      step();
      start = 1'b0; funct3 = 3'b111; endereco = ~a;
      wait_idle();
   endtask

   initial begin
      repeat (3) step();
      chk("reset_busy", 64'(busy[0]), 64'd0);
      chk("reset_dado", dado[2], 64'd0);
      reset = 1'b0;
      step();

      do_load(3'b000, 64'h0000_0000_1000_0003, 64'h0011_2233_8455_6677);
      chk("lb_off3_dado", dado[0], 64'hFFFF_FFFF_FFFF_FF84);
      chk("lb_off3_lat_L1", 64'(obs_lat[0]), 64'd2);
      chk("lb_off3_rd_count", 64'(rd_cnt[0] - rd0[0]), 64'd1);
      chk("lb_off3_addr", mem_addr[0], 64'h0000_0000_1000_0000);

      do_load(3'b000, 64'h0000_0000_1000_0005, 64'h0011_2233_8455_6677);
      chk("lb_off5_dado", dado[1], 64'h0000_0000_0000_0022);

      do_load(3'b101, 64'h0000_0000_2000_0006, 64'hBEEF_0000_0000_0000);
      chk("lhu_off6_dado", dado[2], 64'h0000_0000_0000_BEEF);
      chk("lhu_off6_erro", 64'(obs_err[2]), 64'd0);

      do_load(3'b010, 64'h0000_0000_3000_0002, 64'h1234_5678_9ABC_DEF0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("lw_off2_erro[%0d]", k), 64'(obs_err[k]), 64'd1);
         chk($sformatf("lw_off2_lat[%0d]", k), 64'(obs_lat[k]), 64'd1);
         chk($sformatf("lw_off2_no_rd[%0d]", k), 64'(rd_cnt[k] - rd0[k]), 64'd0);
         chk($sformatf("lw_off2_dado[%0d]", k), dado[k], 64'd0);
      end
      chk("lw_off2_addr_kept", mem_addr[0], 64'h0000_0000_2000_0000);

      do_load(3'b111, 64'h0000_0000_4000_0000, 64'h1234_5678_9ABC_DEF0);
      chk("f3_111_erro", 64'(obs_err[1]), 64'd1);
      chk("f3_111_no_rd", 64'(rd_cnt[1] - rd0[1]), 64'd0);

      do_load(3'b011, 64'h0000_0000_5000_0000, 64'h0123_4567_89AB_CDEF);
      chk("ld_dado_L4", dado[2], 64'h0123_4567_89AB_CDEF);
      chk("ld_lat_L4", 64'(obs_lat[2]), 64'd5);
      chk("ld_busy_cycles_L4", 64'(busy_cnt[2] - busy0[2]), 64'd6);
      chk("ld_rd_count_L4", 64'(rd_cnt[2] - rd0[2]), 64'd1);

      do_load(3'b001, 64'h0000_0000_6000_0002, 64'h0000_0000_8001_0000);
      chk("lh_off2_dado", dado[0], 64'hFFFF_FFFF_FFFF_8001);
      do_load(3'b010, 64'h0000_0000_6000_0004, 64'h89AB_CDEF_0000_0000);
      chk("lw_off4_dado", dado[1], 64'hFFFF_FFFF_89AB_CDEF);
      do_load(3'b110, 64'h0000_0000_6000_0004, 64'h89AB_CDEF_0000_0000);
      chk("lwu_off4_dado", dado[2], 64'h0000_0000_89AB_CDEF);
      do_load(3'b100, 64'h0000_0000_6000_0007, 64'h80FF_FFFF_FFFF_FFFF);
      chk("lbu_off7_dado", dado[0], 64'h0000_0000_0000_0080);
      do_load(3'b101, 64'h0000_0000_6000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("lhu_off1_erro", 64'(obs_err[0]), 64'd1);
      do_load(3'b011, 64'h0000_0000_6000_0004, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ld_off4_erro", 64'(obs_err[2]), 64'd1);

      // start held high: accepts only from IDLE
      snap();
      step();
      funct3 = 3'b000; endereco = 64'h0000_0000_7000_0001; rdata_v = 64'h0000_0000_0000_9900; start = 1'b1;
      repeat (12) step();
      start = 1'b0;
      wait_idle();
      chk("held_rd_L1", 64'(rd_cnt[0] - rd0[0]), 64'd3);
      chk("held_rd_L3", 64'(rd_cnt[1] - rd0[1]), 64'd2);
      chk("held_rd_L4", 64'(rd_cnt[2] - rd0[2]), 64'd2);
      chk("held_dado_L3", dado[1], 64'hFFFF_FFFF_FFFF_FF99);

      // reset in the middle of the L=3 wait
      snap();
      step();
      funct3 = 3'b010; endereco = 64'h0000_0000_8000_0000; rdata_v = 64'h1111_2222_3333_4444; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      chk("rst_mid_busy3", 64'(busy[1]), 64'd0);
      chk("rst_mid_dado3", dado[1], 64'd0);
      chk("rst_mid_addr3", mem_addr[1], 64'd0);
      step();
      reset = 1'b0;
      repeat (6) step();
      chk("rst_mid_no_done3", 64'(done_cnt[1] - done0[1]), 64'd0);
      chk("rst_mid_dado3_held", dado[1], 64'd0);

      do_load(3'b011, 64'h0000_0000_9000_0000, 64'hFEDC_BA98_7654_3210);
      for (int k = 0; k < 3; k++)
         chk($sformatf("after_rst_ld[%0d]", k), dado[k], 64'hFEDC_BA98_7654_3210);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
